// File: rtl/pipe_pkg.sv
// Shared pipeline definitions used by the IF/ID, ID/EX and EX/MEM registers.
//   NOP                    : canonical bubble instruction (addi x0, x0, 0)
//   OP_LUI/OP_AUIPC/OP_JAL : opcodes that read no source registers
//   stage_state_e          : RUN / STALL / FLUSH pipeline-register state
//   has_no_src()           : true for opcodes whose rs1/rs2 fields are not register reads
package pipe_pkg;

    localparam logic [31:0] NOP      = 32'h0000_0013;

    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC = 7'b0010111;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } stage_state_e;

    function automatic logic has_no_src(input logic [6:0] opcode);
        return (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term.
// Fires when the instruction in IF/ID reads a register that the load now in EX will write.
//   opcode_i         : IF/ID instruction opcode field [6:0]
//   rs1_i / rs2_i    : IF/ID instruction source fields [19:15] / [24:20]
//   valid_i          : IF/ID holds a real instruction
//   id_ex_mem_read_i : instruction in EX is a load
//   id_ex_rd_i       : destination register of the instruction in EX
//   hazard_o         : load-use hazard present
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       valid_i,
    input  logic       id_ex_mem_read_i,
    input  logic [4:0] id_ex_rd_i,
    output logic       hazard_o
);

    logic rd_match;

    always_comb begin
        rd_match = (id_ex_rd_i == rs1_i) || (id_ex_rd_i == rs2_i);
        // x0 is never a real dependency; U/J-type fields overlapping rs1/rs2 are immediates.
        hazard_o = valid_i && id_ex_mem_read_i && (id_ex_rd_i != 5'd0) && rd_match &&
                   !has_no_src(opcode_i);
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall and taken-branch flush control.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   fetch_pc/inst/valid   : fetched instruction from IF
//   ID_EX_MemRead/rd      : load-in-EX information for hazard detection
//   branch_taken          : one-cycle taken-branch redirect pulse
//   IF_ID_PC_Out/Inst     : registered PC and instruction
//   IF_ID_valid           : registered instruction is real (not a bubble)
//   pc_write              : PC register may advance
//   id_ex_bubble          : ID/EX must latch zeroed control this cycle
//   stage_state           : 0=RUN, 1=STALL, 2=FLUSH
// Optional (macro IF_ID_HAZARD_STATS_EN): stall_count, flush_count saturating 32-bit counters.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter int unsigned PC_W         = 64,
    parameter int unsigned INST_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic [INST_W-1:0] fetch_inst,
    input  logic              fetch_valid,
    input  logic              ID_EX_MemRead,
    input  logic [4:0]        ID_EX_rd,
    input  logic              branch_taken,
    output logic [PC_W-1:0]   IF_ID_PC_Out,
    output logic [INST_W-1:0] IF_ID_Inst,
    output logic              IF_ID_valid,
    output logic              pc_write,
    output logic              id_ex_bubble,
`ifdef IF_ID_HAZARD_STATS_EN
    output logic [1:0]        stage_state,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count
`else
    output logic [1:0]        stage_state
`endif
);

    localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [INST_W-1:0] NOP_INST   = INST_W'(NOP);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    stage_state_e      state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              hazard;

    load_use_detect u_load_use_detect (
        .opcode_i         (inst_q[6:0]),
        .rs1_i            (inst_q[19:15]),
        .rs2_i            (inst_q[24:20]),
        .valid_i          (valid_q),
        .id_ex_mem_read_i (ID_EX_MemRead),
        .id_ex_rd_i       (ID_EX_rd),
        .hazard_o         (hazard)
    );

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (branch_taken) begin
            // Redirect wins over everything; a second pulse restarts the flush window.
            state_d = FLUSH;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            cnt_d   = FLUSH_LOAD;
        end else begin
            unique case (state_q)
                FLUSH: begin
                    if (cnt_q == 3'd0) begin
                        state_d = RUN;
                        pc_d    = fetch_pc;
                        inst_d  = fetch_valid ? fetch_inst : NOP_INST;
                        valid_d = fetch_valid;
                    end else begin
                        cnt_d   = cnt_q - 3'd1;
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                    end
                end
                RUN, STALL: begin
                    if (hazard) begin
                        state_d = STALL;
                    end else begin
                        state_d = RUN;
                        pc_d    = fetch_pc;
                        inst_d  = fetch_valid ? fetch_inst : NOP_INST;
                        valid_d = fetch_valid;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        IF_ID_PC_Out = pc_q;
        IF_ID_Inst   = inst_q;
        IF_ID_valid  = valid_q;
        stage_state  = state_q;
        pc_write     = !hazard || branch_taken || (state_q == FLUSH);
        id_ex_bubble = hazard || !valid_q || (state_q == FLUSH);
    end

`ifdef IF_ID_HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == STALL) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (branch_taken && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register. It is the producer side that feeds the ID/EX register.
- Latches the fetched PC and instruction each cycle.
- Detects load-use hazards against the instruction currently in ID/EX. On a hazard it holds itself and the PC, and injects a control bubble into ID/EX.
- Flushes wrong-path instructions when a branch resolves taken.
- Contains a RUN/STALL/FLUSH state machine and a flush counter.

Parameters:
- PC_W, 64, width of PC and pipeline data.
- INST_W, 32, instruction width.
- FLUSH_CYCLES, 2, number of cycles IF/ID is forced to NOP after branch_taken (range 1..7).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_pc  in  PC_W  PC of the fetched instruction.
- fetch_inst  in  INST_W  fetched instruction word.
- fetch_valid  in  1  fetch_pc/fetch_inst are valid this cycle.
- ID_EX_MemRead  in  1  instruction now in EX is a load.
- ID_EX_rd  in  5  destination register of the instruction now in EX.
- branch_taken  in  1  taken-branch redirect, one-cycle pulse.
- IF_ID_PC_Out  out  PC_W  registered PC.
- IF_ID_Inst  out  INST_W  registered instruction.
- IF_ID_valid  out  1  registered instruction is real (not a bubble).
- pc_write  out  1  PC register may advance this cycle.
- id_ex_bubble  out  1  ID/EX must latch zeroed control signals this cycle.
- stage_state  out  2  FSM state: 0=RUN, 1=STALL, 2=FLUSH.

Behaviour:
- Reset: one clk edge with reset=1 sets:
  - IF_ID_PC_Out=0
  - IF_ID_Inst=NOP (0x00000013)
  - IF_ID_valid=0
  - state=RUN
  - flush counter=0
- Reset mid-flush or mid-stall returns to RUN in that same cycle.
- Hazard term (combinational), true when all of:
  - IF_ID_valid=1
  - ID_EX_MemRead=1
  - ID_EX_rd≠0
  - ID_EX_rd equals IF_ID_Inst[19:15], or equals IF_ID_Inst[24:20]
  - the opcode IF_ID_Inst[6:0] is not LUI (0110111), AUIPC (0010111) or JAL (1101111); these have no source registers.
- pc_write = !hazard || branch_taken. Combinational. In FLUSH, pc_write=1.
- id_ex_bubble = hazard || !IF_ID_valid || state==FLUSH. Combinational.
- RUN:
  - Each edge loads fetch_pc/fetch_inst.
  - IF_ID_valid is set to fetch_valid.
  - If fetch_valid=0, IF_ID_Inst is loaded with NOP.
- RUN → STALL when hazard and no branch_taken. The register holds its contents.
- STALL:
  - Holds the register while hazard=1.
  - Returns to RUN and loads the fetch inputs on the first edge with hazard=0.
  - A load-use hazard normally lasts exactly 1 cycle.
- Any state → FLUSH on branch_taken. This has priority over the hazard.
  - IF_ID_Inst is set to NOP and IF_ID_valid to 0.
  - The counter is loaded with FLUSH_CYCLES-1.
- FLUSH:
  - Each edge forces NOP / valid=0 and decrements the counter.
  - At counter=0 and no branch_taken, the next edge moves to RUN and loads the fetch inputs normally.
- branch_taken during FLUSH reloads the counter; the flush is extended, not stacked.
- With FLUSH_CYCLES=1: FLUSH lasts exactly one cycle.
- IF_ID_PC_Out is not modified by flush. Only IF_ID_Inst and IF_ID_valid are forced.

Optional Feature:
- Macro IF_ID_HAZARD_STATS_EN.
- When defined, adds outputs:
  - stall_count (32 bits): +1 per cycle in STALL, saturating at 0xFFFFFFFF.
  - flush_count (32 bits): +1 per branch_taken pulse, saturating.
  - Both cleared by reset.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the NOP constant 32'h00000013
  - opcode localparams OP_LUI, OP_AUIPC, OP_JAL
  - the stage_state_e enum (RUN, STALL, FLUSH)
- Shared with the ID/EX and EX/MEM registers.
- One sub-module, load_use_detect: purely combinational hazard term from IF_ID_Inst, IF_ID_valid, ID_EX_MemRead and ID_EX_rd. Reused by the decode-stage forwarding logic.

Test Plan:
- Reset and fill:
  - Stimulus: reset 2 cycles; then fetch_valid=1, fetch_pc=0x100, fetch_inst=0x00A00093.
  - Response: after the edge, IF_ID_PC_Out=0x100, IF_ID_Inst=0x00A00093, IF_ID_valid=1, id_ex_bubble=0.
- Load-use stall:
  - Stimulus: IF_ID_Inst=0x002081B3 (rs1=x1, rs2=x2); ID_EX_MemRead=1, ID_EX_rd=1.
  - Response: pc_write=0, id_ex_bubble=1, register held one cycle, stage_state=1. Next cycle ID_EX_MemRead=0 gives RUN and a new instruction loaded.
- No false stall:
  - Stimulus: ID_EX_rd=0 with MemRead=1, or IF_ID_Inst=LUI 0x000010B7 with ID_EX_rd=1.
  - Response: pc_write=1, no STALL.
- Branch flush:
  - Stimulus: branch_taken pulse at cycle N with FLUSH_CYCLES=2.
  - Response: IF_ID_Inst=0x00000013, valid=0 for cycles N+1 and N+2; cycle N+3 loads the fetch inputs. Branch during STALL goes straight to FLUSH.
- Flush extension and reset mid-flush:
  - Stimulus: second branch_taken one cycle into FLUSH.
  - Response: NOP persists 2 further cycles. reset asserted in FLUSH gives stage_state=0 and valid=0 next edge.
- Stats (with IF_ID_HAZARD_STATS_EN):
  - Stimulus: 3 stalls and 2 branches.
  - Response: stall_count=3, flush_count=2. After reset, both are 0.
